serial_pattern_detector: RTL
============================

# serial_pattern_detector

Synchronous serial pattern detector that consumes a one-bit stream and flags every occurrence of a fixed 4-bit pattern, overlaps included. Matches are counted in a saturating counter. It sits downstream of the combinational gate cells in the lab datapath and is the first clocked consumer of their single-bit outputs. Detection, counting, clear and reset are all synchronous to one clock.

## Interface
- `PATTERN`, default 4'b1011: pattern to detect. Bit 3 is the oldest received bit; bit 0 is the newest.
- `CNT_W`, default 8: width of the match counter. Legal range is 2–16.
- `clk` input 1: sole clock. All state updates on the rising edge.
- `rst_n` input 1: reset. Synchronous, active-low.
- `en` input 1: when high, `din` is sampled on this edge.
- `din` input 1: serial data bit.
- `clear` input 1: synchronous clear of history, counter and flags.
- `match` output 1: registered one-cycle pulse when a match is detected.
- `count` output CNT_W: number of matches since reset or clear. Saturating.
- `sat` output 1: high while `count` equals 2^CNT_W−1.

## Operation
- **History.** A 4-bit shift register `win` holds the sampled bits. On an edge with `en=1`, it updates as `win <= {win[2:0], din}`. On an edge with `en=0`, `win` holds its value.
- **Fill state machine.** States are EMPTY, FILL1, FILL2, FILL3 and ARMED.
  - Each edge with `en=1` advances the state by one: EMPTY→FILL1→FILL2→FILL3→ARMED.
  - ARMED stays ARMED when `en=1`.
  - `en=0` holds the current state.
- **Match rule.** On an edge with `en=1`, if the current state is FILL3 or ARMED and `{win[2:0], din} == PATTERN`, then `match <= 1`. On every other edge, `match <= 0`.
  - Because the state must be FILL3 or ARMED, reset zeros in `win` can never cause a match.
  - An all-zero `PATTERN` therefore needs four genuinely sampled zeros.
- **Overlap.** Detection is overlapping. The bit that completes one match can also start the next.
- **Counter.**
  - On the same edge that sets `match`, `count <= count + 1`, unless `count` is already all-ones, in which case it holds.
  - `sat` is combinational: it equals the AND of all `count` bits.
  - `match` still pulses while the counter is saturated.
- **Clear.** `clear=1` at an edge sets `win`=0, state=EMPTY, `match`=0 and `count`=0.
  - `clear` takes priority over `en`. The `din` sampled on that edge is discarded.
- **Reset.** `rst_n=0` at an edge has the same effect as `clear` and takes priority over everything else.
- **Reset values:**
  - `match`=0
  - `count`=0
  - `sat`=0
  - internally, `win`=4'b0000 and state=EMPTY

## Timing
- **Latency.** One cycle. The completing bit is sampled at edge N, `match` is high from N to N+1, and `count` shows the incremented value from edge N onward.
- **Pulse width.** `match` is high for exactly one cycle per detected match.
  - Back-to-back matches give `match` high on consecutive cycles. This is only possible for periodic patterns such as 4'b1111.
- **Enable gaps.** `en=0` cycles are transparent to detection: bits separated by disabled cycles still form a window. Whenever `en=0`, `match` is 0.
- **Mid-operation.** `clear` or `rst_n` asserted mid-stream takes effect on that edge. Detection restarts from EMPTY, so four new sampled bits are needed before any match.
- **Combinational paths.** No combinational path from any input to `match` or `count`. `sat` depends only on registered `count`.

## Test plan
- **Overlapping matches.** Reset, then `en=1`, `din` = 1,0,1,1,0,1,1 on 7 consecutive edges. Required: `match` high after edge 4 and after edge 7 only; final `count`=2; `sat`=0.
- **Enable gaps.** Same bits, with `en=0` for 3 cycles between bits 2 and 3, and `din` toggling during the gap. Required: `match` only after the 4th and 7th enabled edges; `count`=2.
- **Clear mid-stream.** Feed 1,0,1, then `clear=1` with `en=1` and `din=1`, then feed 1. Required: no `match`, `count`=0, state back to FILL1 after the final bit. Follow with 0,1,1: `match` after the last bit, `count`=1.
- **Saturation.** `CNT_W`=8. Feed 260 non-overlapping matches. Required: `count` stops at 255 after match 255; `sat`=1 from then on; `match` still pulses on matches 256–260.
- **All-zero pattern and reset.** `PATTERN`=4'b0000. Directly after reset, feed `din`=0 for 3 edges: no `match`. The 4th 0 gives `match`=1. Then assert `rst_n=0` for one edge while `en=1`. Required: `match`=0 and `count`=0 after that edge, and the next three 0s give no `match`.

Source files
------------

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: flags every (overlapping) occurrence of PATTERN in a serial bit stream and counts matches
// Ports: clk, rst_n (sync, active-low), en (sample din), din (serial bit), clear (sync clear),
//        match (registered one-cycle pulse), count (saturating match count), sat (count is all-ones)
module serial_pattern_detector #(
    parameter logic [3:0] PATTERN = 4'b1011,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    typedef enum logic [2:0] {EMPTY, FILL1, FILL2, FILL3, ARMED} state_t;
    state_t     state;
    // The oldest bit of the 4-bit window is shifted out before it can ever be compared,
    // so only the three newest sampled bits need storing.
    logic [2:0] hist;
    logic [3:0] win_next;
    logic       hit;
    assign win_next = {hist, din};
    assign hit      = en && (state == FILL3 || state == ARMED) && win_next == PATTERN;
    assign sat      = &count;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= EMPTY;
            hist  <= '0;
            match <= 1'b0;
            count <= '0;
        end else begin
            match <= hit;
            count <= count + CNT_W'(hit && !sat);
            if (en) begin
                hist  <= win_next[2:0];
                state <= state == EMPTY ? FILL1 :
                         state == FILL1 ? FILL2 :
                         state == FILL2 ? FILL3 : ARMED;
            end
        end
    end
endmodule
